// File: rtl/gc_cordic_phase_gen.sv
// rtl/gc_cordic_phase_gen.sv - phase-accumulator NCO front end feeding gc_cordic in rotate mode
module gc_cordic_phase_gen #(
  parameter int g_ACC_BITS       = 32,
  parameter int g_PHASE_BITS     = 16,
  parameter int g_MAG_BITS       = 16,
  parameter int g_CORDIC_LATENCY = 17
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    en_i,
  input  logic [g_ACC_BITS-1:0]   ftw_i,
  input  logic [g_PHASE_BITS-1:0] pofs_i,
  input  logic [g_MAG_BITS-1:0]   mag_i,
  input  logic                    load_i,
  input  logic                    load_mode_i,
  input  logic                    sync_i,
  output logic [g_MAG_BITS-1:0]   x0_o,
  output logic [g_MAG_BITS-1:0]   y0_o,
  output logic [g_PHASE_BITS-1:0] z0_o,
  output logic                    wrap_o,
  output logic                    pending_o,
  output logic                    valid_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_t;

  state_t                  state_q;

  // Active configuration used by the accumulator, and the shadow copy held for a deferred retune.
  logic [g_ACC_BITS-1:0]   ftw_q,  ftw_sh_q;
  logic [g_PHASE_BITS-1:0] pofs_q, pofs_sh_q;
  logic [g_MAG_BITS-1:0]   mag_q,  mag_sh_q;

  logic [g_ACC_BITS-1:0]   acc_q, acc_d;
  logic [g_MAG_BITS-1:0]   x0_q;
  logic [g_PHASE_BITS-1:0] z0_q;
  logic                    wrap_q;

  // Bit k set means a sample entered the CORDIC k+1 cycles ago; the top bit lines up with xn/yn.
  logic [g_CORDIC_LATENCY:0] valid_q, valid_d;

  logic                    step;
  logic [g_ACC_BITS:0]     acc_sum;
  logic                    acc_carry;
  logic [g_PHASE_BITS-1:0] phase_word;

  // Step decode, accumulator add with carry and the phase word presented to the CORDIC.
  always_comb begin
    step       = en_i && (state_q != ST_IDLE);
    acc_sum    = {1'b0, acc_q} + {1'b0, ftw_q};
    acc_carry  = acc_sum[g_ACC_BITS];
    phase_word = acc_q[g_ACC_BITS-1 -: g_PHASE_BITS] + pofs_q;
    valid_d    = {valid_q[g_CORDIC_LATENCY-1:0], step};
    if (sync_i) begin
      acc_d = '0;
    end else if (step) begin
      acc_d = acc_sum[g_ACC_BITS-1:0];
    end else begin
      acc_d = acc_q;
    end
  end

  // Configuration FSM, accumulator, registered CORDIC inputs and valid delay line.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      ftw_q     <= '0;
      pofs_q    <= '0;
      mag_q     <= '0;
      ftw_sh_q  <= '0;
      pofs_sh_q <= '0;
      mag_sh_q  <= '0;
      acc_q     <= '0;
      x0_q      <= '0;
      z0_q      <= '0;
      wrap_q    <= 1'b0;
      valid_q   <= '0;
    end else begin
      acc_q   <= acc_d;
      valid_q <= valid_d;
      wrap_q  <= step && acc_carry && !sync_i;
      if (step) begin
        x0_q <= mag_q;
        z0_q <= phase_word;
      end
      case (state_q)
        ST_IDLE: begin
          // First configuration always takes effect at once, whatever the mode.
          if (load_i) begin
            ftw_q   <= ftw_i;
            pofs_q  <= pofs_i;
            mag_q   <= mag_i;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (load_i && load_mode_i) begin
            ftw_sh_q  <= ftw_i;
            pofs_sh_q <= pofs_i;
            mag_sh_q  <= mag_i;
            state_q   <= ST_PEND;
          end else if (load_i) begin
            ftw_q  <= ftw_i;
            pofs_q <= pofs_i;
            mag_q  <= mag_i;
          end
        end
        ST_PEND: begin
          // A fresh load outranks a coincident wrap; a deferred load just refreshes the shadow.
          if (load_i && !load_mode_i) begin
            ftw_q   <= ftw_i;
            pofs_q  <= pofs_i;
            mag_q   <= mag_i;
            state_q <= ST_RUN;
          end else if (load_i) begin
            ftw_sh_q  <= ftw_i;
            pofs_sh_q <= pofs_i;
            mag_sh_q  <= mag_i;
          end else if (sync_i || (step && acc_carry)) begin
            ftw_q   <= ftw_sh_q;
            pofs_q  <= pofs_sh_q;
            mag_q   <= mag_sh_q;
            state_q <= ST_RUN;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign x0_o      = x0_q;
  assign y0_o      = '0;
  assign z0_o      = z0_q;
  assign wrap_o    = wrap_q;
  assign pending_o = (state_q == ST_PEND);
  assign valid_o   = valid_q[g_CORDIC_LATENCY];

endmodule

// File: tb/tb_gc_cordic_phase_gen.sv
// tb/tb_gc_cordic_phase_gen.sv - self-checking bench for gc_cordic_phase_gen
module tb_gc_cordic_phase_gen;

  localparam int LAT = 17;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        en_i = 1'b0;
  logic [31:0] ftw_i = '0;
  logic [15:0] pofs_i = '0;
  logic [15:0] mag_i = '0;
  logic        load_i = 1'b0;
  logic        load_mode_i = 1'b0;
  logic        sync_i = 1'b0;
  logic [15:0] x0_o, y0_o, z0_o;
  logic        wrap_o, pending_o, valid_o;

  int checks = 0;
  int failures = 0;

  gc_cordic_phase_gen dut (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .ftw_i(ftw_i), .pofs_i(pofs_i),
    .mag_i(mag_i), .load_i(load_i), .load_mode_i(load_mode_i), .sync_i(sync_i),
    .x0_o(x0_o), .y0_o(y0_o), .z0_o(z0_o), .wrap_o(wrap_o),
    .pending_o(pending_o), .valid_o(valid_o)
  );

  always #5 clk = ~clk;

  // Reference model: phase as a plain integer, configuration flags, and a list of sample times.
  longint      m_acc;
  bit          m_cfg, m_pend;
  logic [31:0] m_ftw, s_ftw;
  logic [15:0] m_pofs, s_pofs, m_mag, s_mag;
  logic [15:0] e_x0, e_z0;
  bit          e_wrap, e_valid;
  int          cyc = 0;
  int          sample_cyc[$];

  task automatic tick();
    longint sum;
    bit     stp, carry;
    @(posedge clk);
    cyc++;
    if (rst_i) begin
      m_acc = 0; m_cfg = 0; m_pend = 0;
      m_ftw = 0; m_pofs = 0; m_mag = 0; s_ftw = 0; s_pofs = 0; s_mag = 0;
      e_x0 = 0; e_z0 = 0; e_wrap = 0;
      sample_cyc.delete();
    end else begin
      stp   = en_i && m_cfg;
      sum   = m_acc + longint'(m_ftw);
      carry = stp && (sum >= 64'h1_0000_0000);
      if (stp) begin
        e_z0 = 16'((m_acc / 65536 + longint'(m_pofs)) % 65536);
        e_x0 = m_mag;
        sample_cyc.push_back(cyc);
      end
      e_wrap = carry && !sync_i;
      if (sync_i) m_acc = 0;
      else if (stp) m_acc = sum % 64'h1_0000_0000;
      if (!m_cfg) begin
        if (load_i) begin m_ftw = ftw_i; m_pofs = pofs_i; m_mag = mag_i; m_cfg = 1; end
      end else if (load_i && !load_mode_i) begin
        m_ftw = ftw_i; m_pofs = pofs_i; m_mag = mag_i; m_pend = 0;
      end else if (load_i) begin
        s_ftw = ftw_i; s_pofs = pofs_i; s_mag = mag_i; m_pend = 1;
      end else if (m_pend && (carry || sync_i)) begin
        m_ftw = s_ftw; m_pofs = s_pofs; m_mag = s_mag; m_pend = 0;
      end
    end
    e_valid = 0;
    if (sample_cyc.size() > 0 && sample_cyc[0] == cyc - LAT) begin
      e_valid = 1;
      void'(sample_cyc.pop_front());
    end
    #1;
  endtask

  task automatic drive(bit en, bit ld, bit mode, bit sy, logic [31:0] f, logic [15:0] p, logic [15:0] m);
    en_i = en; load_i = ld; load_mode_i = mode; sync_i = sy; ftw_i = f; pofs_i = p; mag_i = m;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    drive(1, 0, 0, 0, 32'h0, 16'h0, 16'h0);
    tick(); tick();
    rst_i = 1'b0;
    for (int k = 0; k < 30; k++) begin
      tick();
      checks++;
      if (x0_o !== 16'h0 || z0_o !== 16'h0 || y0_o !== 16'h0 || valid_o !== 1'b0 ||
          wrap_o !== 1'b0 || pending_o !== 1'b0) begin
        failures++;
        $display("FAIL reset_idle k=%0d x0=%h z0=%h y0=%h valid=%b wrap=%b pend=%b want all 0",
                 k, x0_o, z0_o, y0_o, valid_o, wrap_o, pending_o);
      end
    end
  endtask

  task automatic test_basic_step();
    drive(0, 1, 1, 0, 32'h0100_0000, 16'h0, 16'd10000);
    tick();
    drive(1, 0, 0, 0, 32'h0, 16'h0, 16'h0);
    for (int k = 0; k < 300; k++) begin
      logic [15:0] ez;
      ez = 16'((k * 256) % 65536);
      tick();
      checks++;
      if (z0_o !== ez || x0_o !== 16'd10000 || wrap_o !== ((k % 256) == 255) ||
          valid_o !== (k >= LAT) || pending_o !== 1'b0) begin
        failures++;
        $display("FAIL basic_step k=%0d z0=%h x0=%0d wrap=%b valid=%b pend=%b want z0=%h x0=10000 wrap=%b valid=%b pend=0",
                 k, z0_o, x0_o, wrap_o, valid_o, pending_o, ez, (k % 256) == 255, k >= LAT);
      end
    end
  endtask

  task automatic test_pofs_wrap();
    drive(0, 1, 0, 1, 32'h0100_0000, 16'h7F00, 16'd10000);
    tick();
    drive(1, 0, 0, 0, 32'h0, 16'h0, 16'h0);
    for (int k = 0; k < 4; k++) begin
      logic [15:0] ez;
      ez = 16'((32'h7F00 + k * 256) % 65536);
      tick();
      checks++;
      if (z0_o !== ez) begin
        failures++;
        $display("FAIL pofs_wrap k=%0d z0=%h want %h", k, z0_o, ez);
      end
    end
  endtask

  task automatic test_deferred();
    drive(0, 1, 0, 1, 32'h0100_0000, 16'h0, 16'd10000);
    tick();
    drive(1, 0, 0, 0, 32'h0, 16'h0, 16'h0);
    repeat (128) tick();
    drive(0, 1, 1, 0, 32'h0300_0000, 16'h0, 16'd30000);
    tick();
    checks++;
    if (pending_o !== 1'b1) begin
      failures++;
      $display("FAIL deferred_pend1 pending=%b want 1", pending_o);
    end
    drive(0, 1, 1, 0, 32'h0200_0000, 16'h0, 16'd20000);
    tick();
    drive(1, 0, 0, 0, 32'h0, 16'h0, 16'h0);
    for (int k = 0; k < 132; k++) begin
      logic [15:0] ez, ex;
      ez = (k <= 128) ? 16'((32'h8000 + k * 256) % 65536) : 16'((k - 128) * 512);
      ex = (k >= 128) ? 16'd20000 : 16'd10000;
      tick();
      checks++;
      if (z0_o !== ez || x0_o !== ex || pending_o !== (k < 127) || wrap_o !== (k == 127)) begin
        failures++;
        $display("FAIL deferred k=%0d z0=%h x0=%0d pend=%b wrap=%b want z0=%h x0=%0d pend=%b wrap=%b",
                 k, z0_o, x0_o, pending_o, wrap_o, ez, ex, k < 127, k == 127);
      end
    end
  endtask

  task automatic test_sync();
    drive(1, 1, 0, 0, 32'h0200_0000, 16'h1234, 16'd20000);
    tick();
    drive(1, 0, 0, 0, 32'h0, 16'h0, 16'h0);
    repeat (5) tick();
    drive(1, 0, 0, 1, 32'h0, 16'h0, 16'h0);
    tick();
    checks++;
    if (wrap_o !== 1'b0 || z0_o !== e_z0) begin
      failures++;
      $display("FAIL sync_same_cycle z0=%h wrap=%b want z0=%h wrap=0", z0_o, wrap_o, e_z0);
    end
    drive(1, 0, 0, 0, 32'h0, 16'h0, 16'h0);
    tick();
    checks++;
    if (z0_o !== 16'h1234) begin
      failures++;
      $display("FAIL sync_restart z0=%h want 1234", z0_o);
    end
    drive(0, 1, 1, 0, 32'h0010_0000, 16'h0, 16'd5);
    tick();
    checks++;
    if (pending_o !== 1'b1) begin
      failures++;
      $display("FAIL sync_pend_set pending=%b want 1", pending_o);
    end
    drive(0, 0, 0, 1, 32'h0, 16'h0, 16'h0);
    tick();
    checks++;
    if (pending_o !== 1'b0) begin
      failures++;
      $display("FAIL sync_pend_clear pending=%b want 0", pending_o);
    end
    drive(1, 0, 0, 0, 32'h0, 16'h0, 16'h0);
    tick();
    checks++;
    if (z0_o !== 16'h0000 || x0_o !== 16'd5) begin
      failures++;
      $display("FAIL sync_shadow0 z0=%h x0=%0d want z0=0000 x0=5", z0_o, x0_o);
    end
    tick();
    checks++;
    if (z0_o !== 16'h0010) begin
      failures++;
      $display("FAIL sync_shadow1 z0=%h want 0010", z0_o);
    end
  endtask

  task automatic test_reset_midstream();
    drive(1, 1, 0, 0, 32'h0123_4567, 16'h0100, 16'd777);
    tick();
    drive(1, 0, 0, 0, 32'h0, 16'h0, 16'h0);
    repeat (30) tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    checks++;
    if (valid_o !== 1'b0 || x0_o !== 16'h0 || z0_o !== 16'h0 || pending_o !== 1'b0 || wrap_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid valid=%b x0=%h z0=%h pend=%b wrap=%b want all 0",
               valid_o, x0_o, z0_o, pending_o, wrap_o);
    end
    for (int k = 0; k < 40; k++) begin
      tick();
      checks++;
      if (valid_o !== 1'b0 || z0_o !== 16'h0) begin
        failures++;
        $display("FAIL reset_mid_hold k=%0d valid=%b z0=%h want valid=0 z0=0", k, valid_o, z0_o);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      logic [31:0] f;
      f = ($urandom_range(0, 3) == 0) ? $urandom() : ($urandom() >> $urandom_range(4, 12));
      rst_i = ($urandom_range(0, 499) == 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 99) == 0, f, 16'($urandom()), 16'($urandom()));
      tick();
      checks++;
      if (x0_o !== e_x0 || y0_o !== 16'h0 || z0_o !== e_z0 || wrap_o !== e_wrap ||
          pending_o !== m_pend || valid_o !== e_valid) begin
        failures++;
        $display("FAIL random k=%0d x0=%h z0=%h y0=%h wrap=%b pend=%b valid=%b want x0=%h z0=%h y0=0 wrap=%b pend=%b valid=%b",
                 k, x0_o, z0_o, y0_o, wrap_o, pending_o, valid_o, e_x0, e_z0, e_wrap, m_pend, e_valid);
      end
    end
    rst_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_step();
    test_pofs_wrap();
    test_deferred();
    test_sync();
    test_reset_midstream();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
